pipe_chain: RTL

- Parametrised elastic pipeline-register chain. It replaces the fixed per-stage latch pairs (if_id, id_ex, ex_mem, mem_wb) with one generic block of DEPTH stages and WIDTH-bit payload.
- Adds behaviour the fixed latches lack: valid/ready handshake, per-stage hold (stall vector), per-stage flush, occupancy reporting and a flush-drop counter.
- Sits between producer and consumer stages of the core. Stage 0 is youngest; stage DEPTH-1 drives the output.

---
 rtl/pipe_chain.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_chain
// Description : Generic elastic pipeline-register chain of DEPTH stages with
//               WIDTH-bit payload. Valid/ready handshake on both ends, a
//               per-stage hold and flush vector, occupancy reporting and a
//               saturating count of entries discarded by flush.
//               Stage 0 is the youngest; stage DEPTH-1 drives the output.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic [DEPTH-1:0]           hold,
    input  logic [DEPTH-1:0]           flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           drop_cnt
);

    // Width of the occupancy / per-cycle drop count, and of the widened
    // drop-counter sum used to detect saturation without wrapping.
    localparam int c_OCC_W = $clog2(DEPTH+1);
    localparam int c_SUM_W = CNT_W + c_OCC_W;

    // ------------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------------
    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [CNT_W-1:0] r_drop_cnt;

    // ------------------------------------------------------------------------
    // Handshake terms
    // ------------------------------------------------------------------------
    logic [DEPTH-1:0] w_alive;      // resident entry survives this cycle
    logic [DEPTH-1:0] w_dn_rdy;     // the stage below can take an entry
    logic [DEPTH-1:0] w_go;         // resident entry moves down this cycle
    logic [DEPTH-1:0] w_free;       // stage can take a new entry this cycle
    logic             w_rdy_chain;  // ripple carrier for the ready chain
    logic             w_acc;        // input transfer this cycle

    // Next-state terms
    logic [DEPTH-1:0] w_load;       // stage loads a new entry at the edge
    logic [DEPTH-1:0] w_v_next;

    // Counting terms
    logic [c_OCC_W-1:0] w_occ;
    logic [c_OCC_W-1:0] w_drop_num;
    logic [c_SUM_W-1:0] w_drop_sum;
    logic [CNT_W-1:0]   w_drop_next;

    // Ready ripples from the output back towards stage 0: a stage is free
    // when it is empty, its resident is being flushed, or it is moving on.
    // Walking top-down inside one block keeps the chain free of loops.
    always_comb begin : p_handshake
        w_alive     = r_v & ~flush;
        w_dn_rdy    = '0;
        w_go        = '0;
        w_free      = '0;
        w_rdy_chain = out_ready;
        for (int i = DEPTH-1; i >= 0; i--) begin
            w_dn_rdy[i] = w_rdy_chain;
            w_go[i]     = w_alive[i] & ~hold[i] & w_dn_rdy[i];
            w_free[i]   = ~r_v[i] | flush[i] | w_go[i];
            w_rdy_chain = w_free[i];
        end
    end

    // The chain refuses input while reset is asserted, even though every
    // stage is already empty at that point.
    assign in_ready = w_free[0] & rst;
    assign w_acc    = in_valid & in_ready;

    // A held or flushed output stage never presents its entry.
    assign out_valid = w_alive[DEPTH-1] & ~hold[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];

    // A stage keeps a surviving resident that does not move, and loads
    // whatever arrives from above; an arrival is kept even if the resident
    // of the same stage is being flushed in that cycle.
    always_comb begin : p_next
        w_load    = '0;
        w_load[0] = w_acc;
        for (int i = 1; i < DEPTH; i++) begin
            w_load[i] = w_go[i-1];
        end
        w_v_next = (w_alive & ~w_go) | w_load;
    end

    // Valid bits of every stage.
    always_ff @(posedge clk or negedge rst) begin : p_valid
        if (!rst) begin
            r_v <= '0;
        end else begin
            r_v <= w_v_next;
        end
    end

    // Payload registers only change on a load, so idle stages stay quiet.
    always_ff @(posedge clk or negedge rst) begin : p_payload
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_d[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_load[i]) begin
                    r_d[i] <= r_d[i-1];
                end
            end
        end
    end

    // Population counts: stored entries, and residents dropped this cycle.
    always_comb begin : p_count
        w_occ      = '0;
        w_drop_num = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ      = w_occ + c_OCC_W'(r_v[i]);
            w_drop_num = w_drop_num + c_OCC_W'(r_v[i] & flush[i]);
        end
    end

    // The sum is formed one field wider than the counter; any carry into
    // the upper field pins the counter at all-ones.
    always_comb begin : p_drop_sat
        w_drop_sum  = c_SUM_W'(r_drop_cnt) + c_SUM_W'(w_drop_num);
        w_drop_next = w_drop_sum[CNT_W-1:0];
        if (|w_drop_sum[c_SUM_W-1:CNT_W]) begin
            w_drop_next = '1;
        end
    end

    // Saturating flush-drop counter.
    always_ff @(posedge clk or negedge rst) begin : p_drop_cnt
        if (!rst) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_next;
        end
    end

    assign occupancy = w_occ;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
